// File: rtl/ctr_defs.sv
`timescale 1ns/100ps
// Shared definitions for blocks consuming the upstream counter: default width and FSM encoding.
package ctr_defs;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/ctr_wrap_det.sv
`timescale 1ns/100ps
// Registers the previous count and flags a clean max->0 step of the upstream counter.
module ctr_wrap_det #(
  parameter int W = ctr_defs::W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt_i,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_i;
  end

  // A jump into 0 from anything other than max is not a period boundary.
  assign wrap_o = (cnt_q == {W{1'b1}}) && (cnt_i == '0);

endmodule

// File: rtl/ctr_pwm.sv
`timescale 1ns/100ps
// PWM generator driven by the free-running counter: double-buffered duty, continuous or
// one-shot (NPER periods) operation; pwm_out and wrap are registered, one clk behind cnt.
module ctr_pwm
  import ctr_defs::*;
#(
  parameter int W    = W_DEF,
  parameter int NPER = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cnt,
  input  logic         en,
  input  logic         oneshot,
  input  logic [W-1:0] duty_in,
  input  logic         duty_wr,
  output logic         pwm_out,
  output logic         wrap,
  output logic         busy,
  output logic         done
);

  localparam int            PW       = $clog2(NPER + 1);
  localparam logic [PW-1:0] PER_LAST = PW'(NPER - 1);

  state_e        state_q, state_d;
  logic          wrap_c;
  logic          active;
  logic          mode_q, mode_d;
  logic          lock_q, lock_d;
  logic [W-1:0]  duty_shadow_q, duty_shadow_d;
  logic [W-1:0]  duty_active_q, duty_active_d;
  logic [W-1:0]  duty_eff;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic          pwm_q, pwm_d;
  logic          wrap_q;

  ctr_wrap_det #(.W(W)) u_wrap_det (
    .clk    (clk),
    .rst    (rst),
    .cnt_i  (cnt),
    .wrap_o (wrap_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en && !lock_q) state_d = ST_ARM;
      ST_ARM: begin
        if (!en)         state_d = ST_IDLE;
        else if (wrap_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en)                                           state_d = ST_IDLE;
        else if (wrap_c && mode_q && per_cnt_q == PER_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ST_ARM, ST_RUN: busy = 1'b1;
      ST_DONE:        done = 1'b1;
      default:        ;
    endcase
  end

  assign active = (state_q == ST_ARM) || (state_q == ST_RUN);

  always_comb begin
    duty_shadow_d = duty_wr ? duty_in : duty_shadow_q;
    // The duty that governs the current cnt: a write on the wrap cycle takes effect at cnt=0.
    duty_eff = duty_active_q;
    if (active && wrap_c) duty_eff = duty_wr ? duty_in : duty_shadow_q;
    duty_active_d = duty_eff;

    per_cnt_d = per_cnt_q;
    if (wrap_c) begin
      if (state_q == ST_ARM)                                 per_cnt_d = '0;
      else if (state_q == ST_RUN && per_cnt_q != {PW{1'b1}}) per_cnt_d = per_cnt_q + PW'(1);
    end

    mode_d = (state_q == ST_IDLE && state_d == ST_ARM) ? oneshot : mode_q;

    // Re-arming after a one-shot needs en to be seen low at least once.
    lock_d = lock_q;
    if (!en)                     lock_d = 1'b0;
    else if (state_q == ST_DONE) lock_d = 1'b1;

    pwm_d = (state_d == ST_RUN) && (cnt < duty_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_shadow_q <= '0;
      duty_active_q <= '0;
      per_cnt_q     <= '0;
      mode_q        <= 1'b0;
      lock_q        <= 1'b0;
      pwm_q         <= 1'b0;
      wrap_q        <= 1'b0;
    end else begin
      duty_shadow_q <= duty_shadow_d;
      duty_active_q <= duty_active_d;
      per_cnt_q     <= per_cnt_d;
      mode_q        <= mode_d;
      lock_q        <= lock_d;
      pwm_q         <= pwm_d;
      wrap_q        <= wrap_c;
    end
  end

  assign pwm_out = pwm_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_ctr_pwm.sv
`timescale 1ns/100ps
// Self-checking bench for ctr_pwm: directed scenarios plus a randomized run against a period-level model.
module tb_ctr_pwm;

  localparam int W    = 4;
  localparam int NPER = 3;
  localparam logic [W-1:0] CMAX = 4'd15;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] cnt;
  logic         en;
  logic         oneshot;
  logic [W-1:0] duty_in;
  logic         duty_wr;
  logic         pwm_out, wrap, busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model: mode flags, periods remaining, pending/current duty.
  bit           m_waiting, m_running, m_finish, m_locked, m_oneshot;
  int           m_left;
  logic [W-1:0] m_shadow, m_duty, m_prev_cnt;
  logic         e_pwm, e_wrap, e_busy, e_done;

  ctr_pwm #(.W(W), .NPER(NPER)) dut (
    .clk     (clk),
    .rst     (rst),
    .cnt     (cnt),
    .en      (en),
    .oneshot (oneshot),
    .duty_in (duty_in),
    .duty_wr (duty_wr),
    .pwm_out (pwm_out),
    .wrap    (wrap),
    .busy    (busy),
    .done    (done)
  );

  always #1 clk = ~clk;

  task automatic model_clear();
    m_waiting = 0; m_running = 0; m_finish = 0; m_locked = 0; m_oneshot = 0;
    m_left = 0; m_shadow = '0; m_duty = '0; m_prev_cnt = '0;
    e_pwm = 0; e_wrap = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic model_step();
    bit wrapev, was_finish;
    if (rst) begin
      model_clear();
      return;
    end
    wrapev     = (m_prev_cnt == CMAX) && (cnt == '0);
    was_finish = m_finish;
    if (duty_wr) m_shadow = duty_in;
    if (m_finish) begin
      m_finish = 0;
    end else if (m_waiting) begin
      if (!en) m_waiting = 0;
      else if (wrapev) begin
        m_waiting = 0; m_running = 1; m_duty = m_shadow; m_left = NPER;
      end
    end else if (m_running) begin
      if (!en) m_running = 0;
      else if (wrapev) begin
        m_duty = m_shadow;
        if (m_oneshot) begin
          m_left--;
          if (m_left == 0) begin m_running = 0; m_finish = 1; end
        end
      end
    end else if (en && !m_locked) begin
      m_waiting = 1; m_oneshot = oneshot;
    end
    if (!en) m_locked = 0;
    else if (was_finish) m_locked = 1;
    m_prev_cnt = cnt;
    e_wrap = wrapev;
    e_busy = m_waiting || m_running;
    e_done = m_finish;
    e_pwm  = m_running && (cnt < m_duty);
  endtask

  // One clock: model consumes current inputs, DUT clocks, upstream counter advances.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cnt = cnt + 4'd1;
  endtask

  task automatic wait_wrap(output bit ok, output int n, output int pre_hi);
    n = 0; pre_hi = 0;
    while (wrap !== 1'b1 && n < 40) begin
      pre_hi += int'(pwm_out === 1'b1);
      tick();
      n++;
    end
    ok = (wrap === 1'b1);
  endtask

  // Observes 16 samples starting on a period's first sample; optional duty write at sample wr_at.
  task automatic run_period(input int wr_at, input logic [W-1:0] wr_val, output int hi, output int wr);
    hi = 0; wr = 0;
    for (int i = 0; i < 16; i++) begin
      hi += int'(pwm_out === 1'b1);
      wr += int'(wrap === 1'b1);
      if (i == wr_at) begin duty_in = wr_val; duty_wr = 1'b1; end
      tick();
      duty_wr = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cnt = '0; en = 1'b0; oneshot = 1'b0; duty_in = '0; duty_wr = 1'b0;
    model_clear();
    #0.5;
    checks++;
    if ({pwm_out, wrap, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_async: pwm/wrap/busy/done=%b%b%b%b, want 0000", pwm_out, wrap, busy, done);
    end
    tick();
    checks++;
    if ({pwm_out, wrap, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_clocked: pwm/wrap/busy/done=%b%b%b%b, want 0000", pwm_out, wrap, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_continuous();
    int hi, wr, n, pre;
    bit ok;
    duty_in = 4'd5; duty_wr = 1'b1; tick(); duty_wr = 1'b0;
    en = 1'b1; oneshot = 1'b0; tick();
    checks++;
    if (busy !== 1'b1 || pwm_out !== 1'b0) begin
      errors++; $display("FAIL t1_arm: busy=%b pwm=%b, want busy=1 pwm=0", busy, pwm_out);
    end
    wait_wrap(ok, n, pre);
    checks++;
    if (!ok || n != 14 || pre != 0 || pwm_out !== 1'b1) begin
      errors++; $display("FAIL t1_run_start: ok=%0d cycles=%0d pre_hi=%0d pwm=%b, want 1/14/0/1", ok, n, pre, pwm_out);
    end
    for (int p = 0; p < 3; p++) begin
      run_period(-1, '0, hi, wr);
      checks++;
      if (hi != 5 || wr != 1) begin
        errors++; $display("FAIL t1_period%0d: high=%0d wraps=%0d, want 5/1", p, hi, wr);
      end
    end
    checks++;
    if ({pwm_out, wrap, busy, done} !== {e_pwm, e_wrap, e_busy, e_done}) begin
      errors++; $display("FAIL t1_model: got %b%b%b%b, want %b%b%b%b", pwm_out, wrap, busy, done, e_pwm, e_wrap, e_busy, e_done);
    end
  endtask

  task automatic test_shadow(output logic [W-1:0] d);
    int hi, wr;
    run_period(7, 4'd12, hi, wr);
    checks++;
    if (hi != 5) begin errors++; $display("FAIL t2_keep_old: high=%0d, want 5", hi); end
    run_period(-1, '0, hi, wr);
    checks++;
    if (hi != 12 || wr != 1) begin errors++; $display("FAIL t2_new_duty: high=%0d wraps=%0d, want 12/1", hi, wr); end
    d = 4'($urandom_range(1, 14));
    if (d == 4'd12) d = 4'd11;
    run_period(15, d, hi, wr);
    checks++;
    if (hi != 12) begin errors++; $display("FAIL t2_before_bypass: high=%0d, want 12", hi); end
    run_period(-1, '0, hi, wr);
    checks++;
    if (hi != int'(d)) begin errors++; $display("FAIL t2_bypass: high=%0d, want %0d", hi, d); end
  endtask

  task automatic test_bounds(input logic [W-1:0] d);
    int hi, wr;
    run_period(7, 4'd0, hi, wr);
    checks++;
    if (hi != int'(d)) begin errors++; $display("FAIL t4_prev: high=%0d, want %0d", hi, d); end
    run_period(7, 4'd15, hi, wr);
    checks++;
    if (hi != 0) begin errors++; $display("FAIL t4_duty0: high=%0d, want 0", hi); end
    run_period(-1, '0, hi, wr);
    checks++;
    if (hi != 15 || wr != 1) begin errors++; $display("FAIL t4_duty15: high=%0d wraps=%0d, want 15/1", hi, wr); end
    tick(); tick();
    checks++;
    if (pwm_out !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL t4_pre_stop: pwm=%b busy=%b, want 1/1", pwm_out, busy);
    end
    en = 1'b0;
    tick();
    checks++;
    if (pwm_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL t4_stop: pwm=%b busy=%b done=%b, want 0/0/0", pwm_out, busy, done);
    end
  endtask

  task automatic test_oneshot();
    int hi, wr, n, pre, seen;
    bit ok;
    duty_in = 4'd5; duty_wr = 1'b1; tick(); duty_wr = 1'b0;
    oneshot = 1'b1; en = 1'b1; tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL t3_arm: busy=%b, want 1", busy); end
    wait_wrap(ok, n, pre);
    checks++;
    if (!ok || pre != 0) begin errors++; $display("FAIL t3_start: ok=%0d pre_hi=%0d, want 1/0", ok, pre); end
    for (int p = 0; p < NPER; p++) begin
      run_period(-1, '0, hi, wr);
      checks++;
      if (hi != 5 || wr != 1) begin errors++; $display("FAIL t3_period%0d: high=%0d wraps=%0d, want 5/1", p, hi, wr); end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pwm_out !== 1'b0) begin
      errors++; $display("FAIL t3_done: done=%b busy=%b pwm=%b, want 1/0/0", done, busy, pwm_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL t3_done_pulse: done=%b busy=%b, want 0/0", done, busy);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen += int'(busy === 1'b1 || done === 1'b1 || pwm_out === 1'b1);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL t3_stay_idle: active samples=%0d, want 0", seen); end
  endtask

  task automatic test_bad_count();
    int hi, wr, n, pre;
    bit ok;
    en = 1'b0; tick();
    en = 1'b1; oneshot = 1'b1; tick();
    wait_wrap(ok, n, pre);
    checks++;
    if (!ok) begin errors++; $display("FAIL t6_start: no wrap within %0d cycles", n); end
    hi = 0; wr = 0;
    for (int i = 0; i < 16; i++) begin
      hi += int'(pwm_out === 1'b1);
      wr += int'(wrap === 1'b1);
      if (i == 7) begin duty_in = 4'd9; duty_wr = 1'b1; end
      tick();
      duty_wr = 1'b0;
      if (i == 14) cnt = 4'd7;
      if (i == 15) cnt = 4'd0;
    end
    checks++;
    if (hi != 5 || wr != 1) begin errors++; $display("FAIL t6_first: high=%0d wraps=%0d, want 5/1", hi, wr); end
    checks++;
    if (wrap !== 1'b0 || pwm_out !== 1'b0) begin
      errors++; $display("FAIL t6_jump7: wrap=%b pwm=%b, want 0/0", wrap, pwm_out);
    end
    tick();
    checks++;
    if (wrap !== 1'b0 || pwm_out !== 1'b1) begin
      errors++; $display("FAIL t6_7to0: wrap=%b pwm=%b, want 0/1", wrap, pwm_out);
    end
    run_period(-1, '0, hi, wr);
    checks++;
    if (hi != 5 || wr != 0) begin errors++; $display("FAIL t6_no_reload: high=%0d wraps=%0d, want 5/0", hi, wr); end
    for (int p = 0; p < 2; p++) begin
      run_period(-1, '0, hi, wr);
      checks++;
      if (hi != 9 || wr != 1 || done !== (p == 1)) begin
        errors++; $display("FAIL t6_period%0d: high=%0d wraps=%0d done=%b, want 9/1/%0d", p, hi, wr, done, p == 1);
      end
    end
  endtask

  task automatic test_async_reset();
    int n, pre;
    bit ok;
    en = 1'b0; tick();
    oneshot = 1'b0; en = 1'b1; tick();
    wait_wrap(ok, n, pre);
    tick();
    checks++;
    if (!ok || pwm_out !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL t5_pre: ok=%0d pwm=%b busy=%b, want 1/1/1", ok, pwm_out, busy);
    end
    #0.5 rst = 1'b1;
    #0.2;
    checks++;
    if ({pwm_out, wrap, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL t5_async: pwm/wrap/busy/done=%b%b%b%b, want 0000", pwm_out, wrap, busy, done);
    end
    tick();
    checks++;
    if ({pwm_out, wrap, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL t5_held: pwm/wrap/busy/done=%b%b%b%b, want 0000", pwm_out, wrap, busy, done);
    end
    rst = 1'b0;
    duty_in = 4'd5; duty_wr = 1'b1; tick(); duty_wr = 1'b0;
    checks++;
    if (busy !== 1'b1 || pwm_out !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL t5_rearm: busy=%b pwm=%b done=%b, want 1/0/0", busy, pwm_out, done);
    end
    wait_wrap(ok, n, pre);
    checks++;
    if (!ok || pre != 0 || pwm_out !== 1'b1) begin
      errors++; $display("FAIL t5_run: ok=%0d pre_hi=%0d pwm=%b, want 1/0/1", ok, pre, pwm_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if (en) begin
        if ($urandom_range(0, 119) == 0) en = 1'b0;
      end else begin
        oneshot = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) en = 1'b1;
      end
      duty_wr = ($urandom_range(0, 7) == 0);
      duty_in = 4'($urandom);
      if ($urandom_range(0, 99) == 0) cnt = 4'($urandom);
      tick();
      duty_wr = 1'b0;
      checks++;
      if ({pwm_out, wrap, busy, done} !== {e_pwm, e_wrap, e_busy, e_done}) begin
        errors++;
        $display("FAIL rand_cycle%0d: pwm/wrap/busy/done=%b%b%b%b, want %b%b%b%b",
                 c, pwm_out, wrap, busy, done, e_pwm, e_wrap, e_busy, e_done);
      end
    end
  endtask

  initial begin
    logic [W-1:0] d;
    test_reset();
    test_continuous();
    test_shadow(d);
    test_bounds(d);
    test_oneshot();
    test_bad_count();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
